// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_pkg
// Brief    : Shared glyph geometry, BCD constants and converter FSM encoding
//            for the VGA number renderer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

  // Glyph cell geometry in pixels
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  // One decimal digit per BCD nibble
  localparam int BCD_W = 4;

  // Double-dabble correction: nibbles at or above this get +3 before a shift
  localparam int ADD3_THRESH = 5;

  // Converter / commit FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PENDING = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter. Saturates
//            inputs that do not fit in NUM_DIGITS decimal digits and flags
//            the saturation. o_last marks the final shift cycle; the result
//            and flag hold until the next i_start.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import vga_text_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [VALUE_W-1:0]          i_value,
  output logic                        o_last,
  output logic [BCD_W*NUM_DIGITS-1:0] o_bcd,
  output logic                        o_ovf
);

  localparam int          c_BCD_BITS = BCD_W * NUM_DIGITS;
  localparam int          c_CNT_W    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [63:0] c_LIMIT    = 64'(10 ** NUM_DIGITS);
  localparam logic [VALUE_W-1:0] c_SAT = VALUE_W'(c_LIMIT - 64'd1);

  state_t                    r_state;
  logic [VALUE_W-1:0]        r_bin;
  logic [c_BCD_BITS-1:0]     r_bcd;
  logic [c_CNT_W-1:0]        r_cnt;
  logic                      r_ovf;

  logic [c_BCD_BITS-1:0]         w_adj;
  logic [c_BCD_BITS+VALUE_W-1:0] w_shifted;
  logic                          w_sat;

  assign w_sat = (64'(i_value) >= c_LIMIT);

  // Add-3 correction on every nibble, then shift the combined register left
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i*BCD_W +: BCD_W] >= BCD_W'(ADD3_THRESH))
        w_adj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + BCD_W'(3);
    end
    w_shifted = {w_adj, r_bin} << 1;
  end

  assign o_last = (r_state == ST_SHIFT) && (r_cnt == c_CNT_W'(VALUE_W - 1));
  assign o_bcd  = r_bcd;
  assign o_ovf  = r_ovf;

  // Load the (possibly saturated) operand, then run VALUE_W shift cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_bin   <= w_sat ? c_SAT : i_value;
            r_ovf   <= w_sat;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_shifted[c_BCD_BITS+VALUE_W-1 -: c_BCD_BITS];
          r_bin <= w_shifted[VALUE_W-1:0];
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (o_last)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_number_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_number_renderer
// Brief    : Converts a binary value to decimal and draws it as a row of
//            8x16 glyphs at (X0,Y0). New values reach the display only on a
//            frame_start pulse so a frame is never torn. Two-cycle pipeline
//            from hcount/vcount to pixel_on.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module vga_number_renderer
  import vga_text_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter int         VALUE_W    = 14,
  parameter logic [9:0] X0         = 10'd100,
  parameter logic [9:0] Y0         = 10'd200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               frame_start,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               video_on,
  output logic [3:0]         digit_code,
  output logic [3:0]         glyph_row,
  output logic [2:0]         glyph_col,
  input  logic               glyph_pixel,
  output logic               pixel_on,
  output logic               ovf
);

  localparam int          c_BCD_BITS = BCD_W * NUM_DIGITS;
  localparam logic [10:0] c_BOX_W    = 11'(GLYPH_W * NUM_DIGITS);
  localparam logic [10:0] c_BOX_H    = 11'(GLYPH_H);

  state_t                r_state;
  logic [c_BCD_BITS-1:0] r_disp;
  logic                  r_ovf;
  logic                  r_in_box_q;

  logic                  w_start;
  logic                  w_last;
  logic [c_BCD_BITS-1:0] w_bcd;
  logic                  w_bcd_ovf;
  logic                  w_in_box;
  logic [9:0]            w_dx;
  logic [6:0]            w_di;
  logic [3:0]            w_row;
  logic [BCD_W-1:0]      w_digit;
  logic                  w_blank_q;

  assign value_ready = (r_state == ST_IDLE);
  assign ovf         = r_ovf;
  assign w_start     = value_valid && value_ready;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_value (value_in),
    .o_last  (w_last),
    .o_bcd   (w_bcd),
    .o_ovf   (w_bcd_ovf)
  );

  // Track the converter, then hold the result until the next frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_start)     r_state <= ST_SHIFT;
        ST_SHIFT:   if (w_last)      r_state <= ST_PENDING;
        ST_PENDING: if (frame_start) r_state <= ST_COMMIT;
        ST_COMMIT: begin
          r_disp  <= w_bcd;
          r_ovf   <= w_bcd_ovf;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Box test in 11 bits so the right/bottom edge cannot wrap
  assign w_in_box = video_on
                 && ({1'b0, hcount} >= {1'b0, X0})
                 && ({1'b0, hcount} <  {1'b0, X0} + c_BOX_W)
                 && ({1'b0, vcount} >= {1'b0, Y0})
                 && ({1'b0, vcount} <  {1'b0, Y0} + c_BOX_H);
  assign w_dx  = hcount - X0;
  assign w_di  = w_dx[9:3];
  assign w_row = vcount[3:0] - Y0[3:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic w_blank;
  logic w_zero_run;
  logic r_blank_q;

  // Select the cell's digit; blank it if it and everything left of it is 0
  always_comb begin
    w_digit    = '0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_zero_run = w_zero_run && (r_disp[c_BCD_BITS-1-d*BCD_W -: BCD_W] == '0);
      if (w_di == 7'(d)) begin
        w_digit = r_disp[c_BCD_BITS-1-d*BCD_W -: BCD_W];
        w_blank = w_zero_run && (d != NUM_DIGITS - 1);
      end
    end
  end

  // Blank flag travels alongside the glyph address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_blank_q <= 1'b0;
    else if (w_in_box)
      r_blank_q <= w_blank;
  end

  assign w_blank_q = r_blank_q;
`else
  // Select the cell's digit (di = 0 is the most significant)
  always_comb begin
    w_digit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_di == 7'(d))
        w_digit = r_disp[c_BCD_BITS-1-d*BCD_W -: BCD_W];
    end
  end

  assign w_blank_q = 1'b0;
`endif

  // Stage 1: glyph ROM address; held outside the box
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_code <= '0;
      glyph_row  <= '0;
      glyph_col  <= '0;
      r_in_box_q <= 1'b0;
    end else begin
      r_in_box_q <= w_in_box;
      if (w_in_box) begin
        digit_code <= w_digit;
        glyph_row  <= w_row;
        glyph_col  <= 3'd7 - w_dx[2:0];
      end
    end
  end

  // Stage 2: register the foreground decision from the ROM bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pixel_on <= 1'b0;
    else
      pixel_on <= r_in_box_q && glyph_pixel && !w_blank_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_number_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_number_renderer
// Brief    : Self-checking bench for vga_number_renderer with a random glyph
//            ROM, a decimal display model and a queue-based raster scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_number_renderer;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int BX = 100;
  localparam int BY = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] value_in;
  logic          value_valid;
  logic          value_ready;
  logic          frame_start;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic          video_on;
  logic [3:0]    digit_code;
  logic [3:0]    glyph_row;
  logic [2:0]    glyph_col;
  logic          glyph_pixel;
  logic          pixel_on;
  logic          ovf;

  always #5 clk = ~clk;

  vga_number_renderer #(
    .NUM_DIGITS (ND),
    .VALUE_W    (VW),
    .X0         (10'd100),
    .Y0         (10'd200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .frame_start (frame_start),
    .hcount      (hcount),
    .vcount      (vcount),
    .video_on    (video_on),
    .digit_code  (digit_code),
    .glyph_row   (glyph_row),
    .glyph_col   (glyph_col),
    .glyph_pixel (glyph_pixel),
    .pixel_on    (pixel_on),
    .ovf         (ovf)
  );

  // Behavioural glyph ROM: bit 7 of each row byte is the leftmost pixel
  logic [7:0] rom [0:9][0:15];
  always_comb begin
    glyph_pixel = 1'b0;
    if (digit_code <= 4'd9)
      glyph_pixel = rom[digit_code][glyph_row][glyph_col];
  end

  // Model of what the screen should show
  int disp [ND];
  int mdl_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit inbox;
    int dig;
    int row;
    int col;
  } addr_t;

  addr_t qa[$];
  bit    qp[$];
  bit    sv = 1'b0;
  bit    v1 = 1'b0;
  bit    v2 = 1'b0;

  // Tags marking which cycles carry a scoreboard entry through the pipe
  always @(posedge clk) begin
    v1 <= sv;
    v2 <= v1;
  end

  // Monitor: compare the address one cycle and the pixel two cycles after drive
  always @(negedge clk) begin
    addr_t a;
    bit    e;
    if (v1) begin
      if (qa.size() == 0) begin
        check("addr_queue_empty", 1, 0);
      end else begin
        a = qa.pop_front();
        if (a.inbox) begin
          check("digit_code", 32'(digit_code), 32'(a.dig));
          check("glyph_row",  32'(glyph_row),  32'(a.row));
          check("glyph_col",  32'(glyph_col),  32'(a.col));
        end
      end
    end
    if (v2) begin
      if (qp.size() == 0) begin
        check("pixel_queue_empty", 1, 0);
      end else begin
        e = qp.pop_front();
        check("pixel_on", 32'(pixel_on), 32'(e));
      end
    end
  end

  function automatic bit leading_blank(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == ND - 1) return 1'b0;
    for (int k = 0; k <= d; k++)
      if (disp[k] != 0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one raster position and push its expected results
  task automatic drive_pix(input int h, input int v, input bit von);
    addr_t a;
    bit    pix;
    int    dx;
    @(negedge clk);
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = von;
    sv       = 1'b1;
    a.inbox  = von && (h >= BX) && (h < BX + 8 * ND) && (v >= BY) && (v < BY + 16);
    a.dig = 0; a.row = 0; a.col = 0;
    pix = 1'b0;
    if (a.inbox) begin
      dx    = h - BX;
      a.dig = disp[dx / 8];
      a.row = v - BY;
      a.col = 7 - (dx % 8);
      pix   = !leading_blank(dx / 8) && rom[a.dig][a.row][a.col];
    end
    qa.push_back(a);
    qp.push_back(pix);
  endtask

  task automatic scan_rows();
    int rows [7];
    rows = '{199, 200, 202, 209, 215, 216, 0};
    rows[6] = int'($urandom_range(200, 215));
    foreach (rows[r])
      for (int h = 96; h < 136; h++)
        drive_pix(h, rows[r], $urandom_range(0, 7) != 0);
    @(negedge clk);
    sv       = 1'b0;
    video_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Offer a value, walk the conversion and commit it on a frame_start pulse
  task automatic commit_value(input int val, input bit late_fs, input bit extra_valid, input int hold);
    int sat;
    @(negedge clk);
    value_in    = VW'(val);
    value_valid = 1'b1;
    check("ready_at_offer", 32'(value_ready), 1);
    for (int i = 1; i <= VW; i++) begin
      @(negedge clk);
      value_valid = 1'b0;
      frame_start = 1'b0;
      check("ready_in_shift", 32'(value_ready), 0);
      if (i == VW && late_fs) frame_start = 1'b1;
    end
    @(negedge clk);
    frame_start = 1'b0;
    if (late_fs || extra_valid || hold > 0) begin
      if (extra_valid) begin
        value_in    = VW'($urandom_range(0, 16383));
        value_valid = 1'b1;
      end
      repeat (hold) @(negedge clk);
      check("ready_pending", 32'(value_ready), 0);
      value_valid = 1'b0;
      scan_rows();
      check("ready_pending_after_scan", 32'(value_ready), 0);
      @(negedge clk);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("ready_in_commit", 32'(value_ready), 0);
    sat = (val >= 10 ** ND) ? 10 ** ND - 1 : val;
    for (int d = 0; d < ND; d++)
      disp[ND - 1 - d] = (sat / (10 ** d)) % 10;
    mdl_ovf = (val >= 10 ** ND) ? 1 : 0;
    @(negedge clk);
    check("ready_after_commit", 32'(value_ready), 1);
    check("ovf", 32'(ovf), 32'(mdl_ovf));
    scan_rows();
  endtask

  task automatic check_reset_outputs();
    check("rst_value_ready", 32'(value_ready), 1);
    check("rst_digit_code",  32'(digit_code),  0);
    check("rst_glyph_row",   32'(glyph_row),   0);
    check("rst_glyph_col",   32'(glyph_col),   0);
    check("rst_pixel_on",    32'(pixel_on),    0);
    check("rst_ovf",         32'(ovf),         0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 10; d++)
      for (int r = 0; r < 16; r++)
        rom[d][r] = 8'($urandom);
    foreach (disp[d]) disp[d] = 0;
    mdl_ovf     = 0;
    rst         = 1'b1;
    value_in    = '0;
    value_valid = 1'b0;
    frame_start = 1'b0;
    hcount      = '0;
    vcount      = '0;
    video_on    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    scan_rows();                           // reset display 0000
    commit_value(1234,  1'b0, 1'b0, 0);
    commit_value(16383, 1'b0, 1'b0, 0);    // saturates to 9999
    commit_value(42,    1'b0, 1'b0, 0);
    commit_value(555,   1'b0, 1'b0, 1000); // long wait in PENDING
    commit_value(8001,  1'b0, 1'b1, 5);    // valid during PENDING ignored
    commit_value(3090,  1'b1, 1'b0, 0);    // frame_start on last shift cycle

    // Reset in the middle of a conversion
    @(negedge clk);
    value_in    = VW'(9876);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    foreach (disp[d]) disp[d] = 0;
    mdl_ovf = 0;
    scan_rows();
    commit_value(7, 1'b0, 1'b0, 0);
    commit_value(0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 4; k++)
      commit_value(int'($urandom_range(0, 16383)), 1'b0, 1'b0, int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_number_renderer.md
Name: vga_number_renderer

Overview:
- Converts a binary matrix-result value to decimal with a sequential double-dabble engine, then renders it as a line of 8x16 glyphs on the VGA raster.
- Drives the glyph ROM's digit_code/row/col address, samples its 1-bit pixel return, and outputs a registered foreground-pixel flag for the colour mux.
- Sits between the matrix-result register, the VGA timing generator and the glyph ROM.

Parameters:
- NUM_DIGITS, 4, decimal digits displayed; most significant digit is leftmost.
- VALUE_W, 14, width of the binary input value.
- X0, 10'd100, left pixel column of the text box.
- Y0, 10'd200, top pixel row of the text box.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  VALUE_W  unsigned binary value to display.
- value_valid  in  1  value_in is offered.
- value_ready  out  1  converter idle; accepts on valid&&ready.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- video_on  in  1  active video region.
- digit_code  out  4  glyph ROM digit select, 0-9.
- glyph_row  out  4  glyph ROM row, 0-15.
- glyph_col  out  3  glyph ROM column; bit index, so col 7 is the leftmost pixel.
- glyph_pixel  in  1  glyph ROM output, combinational from the address.
- pixel_on  out  1  foreground pixel, registered.
- ovf  out  1  the last committed value was saturated.

Behaviour:
- Reset values: value_ready=1, digit_code=0, glyph_row=0, glyph_col=0, pixel_on=0, ovf=0. Displayed digits reset to all 0, the FSM to IDLE, and any staging register clears. Reset asserted mid-conversion or while PENDING discards the value.
- FSM states are IDLE, SHIFT, PENDING and COMMIT.
- IDLE: value_ready=1. On valid&&ready, load the operand and go to SHIFT.
  - If value_in >= 10**NUM_DIGITS, load 10**NUM_DIGITS-1 and set the staged ovf. Otherwise clear the staged ovf.
- SHIFT: a VALUE_W-cycle counter runs. Each cycle, every BCD nibble >=5 gets +3, then the combined {bcd,bin} register shifts left by 1. The BCD register is 4*NUM_DIGITS bits. After VALUE_W cycles, go to PENDING.
- PENDING: hold the result. On frame_start, go to COMMIT. A frame_start coincident with the last SHIFT cycle is not honoured.
- COMMIT: one cycle. Copy BCD digits and staged ovf into the display registers, then return to IDLE. value_ready is 1 on the cycle after COMMIT.
- value_ready=0 in SHIFT, PENDING and COMMIT; value_valid is ignored there. The display never changes mid-frame.
- Render pipeline, stage 1 (registered):
  - in_box = video_on && X0<=hcount<X0+8*NUM_DIGITS && Y0<=vcount<Y0+16.
  - dx=hcount-X0, di=dx>>3.
  - digit_code = display digit di (di=0 is most significant), glyph_row=vcount-Y0, glyph_col=7-dx[2:0].
  - Outside the box, the address registers hold their previous value and in_box_q=0.
- Render pipeline, stage 2 (registered): pixel_on = in_box_q && glyph_pixel && !blank_q.
- Latency from hcount/vcount to pixel_on is 2 cycles. The timing generator delays its syncs by 2 to match.
- Box arithmetic is done in 11 bits so X0+8*NUM_DIGITS does not wrap.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: stage 1 sets blank_q for any digit that is 0 and has only zeros to its left. The least significant digit is never blanked, so value 0 shows a single "0" in the rightmost cell.
- Undefined: blank_q is tied to 0 and all NUM_DIGITS digits, including leading zeros, are drawn.

Decomposition:
- Package vga_text_pkg holds:
  - GLYPH_W=8 and GLYPH_H=16.
  - The FSM state encoding.
  - The BCD nibble width 4.
  - The add-3 threshold 5.
- One natural sub-module, bin2bcd_seq: the IDLE/SHIFT engine with start/done handshake, parameterised by VALUE_W and NUM_DIGITS.
- The renderer top keeps PENDING/COMMIT, the display registers and the pixel pipeline.

Test Plan:
- Conversion: value_in=1234 accepted → value_ready low 14 SHIFT cycles, then PENDING; after frame_start + COMMIT, digits=1,2,3,4, ovf=0, ready=1 one cycle after COMMIT.
- Raster readout: X0=100, Y0=200 with a behavioural glyph ROM model, scanning row vcount=202 → digit_code=1 at hcount 100-107 and 4 at 124-131, glyph_row=2, glyph_col 7..0 across each cell; pixel_on equals ROM bit 7-dx delayed 2 cycles; pixel_on=0 at hcount 99/132, vcount 199/216 and whenever video_on=0.
- Saturation: value_in=16383 → digits 9,9,9,9 and ovf=1 after commit; then value_in=42 → ovf=0.
- Frame-boundary commit:
  - Hold frame_start low for 1000 cycles after conversion → display unchanged, ready=0.
  - Assert value_valid during PENDING → ignored.
  - frame_start on the last SHIFT cycle → no commit until the next pulse.
- Reset mid-SHIFT: rst after 5 shift cycles → all outputs at reset values, display 0000; next value 7 converts normally.
- LEADING_ZERO_BLANK_EN:
  - Defined, value 7: pixel_on=0 over cells 0-2, drawn in cell 3.
  - Defined, value 0: only cell 3 drawn.
  - Undefined, value 7: "0007" drawn.
